des_keysched_seq: RTL and testbench
===================================

Name: des_keysched_seq

Overview:
Runtime-keyed successor to the fixed-key DES round-key ROM. It loads a 64-bit DES key, expands the 16 round keys sequentially (PC-1, per-round C/D rotation, PC-2), and stores them in an internal 16x48 table. A registered read port returns any round key, in encrypt order or reversed decrypt order. It sits beside the DES round datapath and replaces the constant ROM wherever the key must change without resynthesis.

Parameters:
DEFAULT_KEY, 64'hFEF9545BB7A45DFD, key loaded into the key register at reset.
AUTO_EXPAND, 1, 1: expansion starts automatically after reset release; 0: table stays invalid until the first key_load.

Ports:
clk  in  1  single clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
key_load  in  1  one-cycle strobe; captures key_in and starts expansion
key_in  in  64  DES key, MSB = DES bit 1; parity bits (8,16,...,64) ignored via PC-1
busy  out  1  expansion in progress
ready  out  1  table holds a complete, consistent schedule for the current key
rd_en  in  1  read request
rd_round  in  4  logical round index 0..15
rd_decrypt  in  1  1: physical index = 15 - rd_round
roundkey  out  48  round key, MSB = PC-2 bit 1
rd_valid  out  1  roundkey valid for the request of the previous cycle

Behaviour:
- Reset (async, rst_n=0): key_reg=DEFAULT_KEY, C/D=0, cnt=0, ready=0, busy=0, rd_valid=0, roundkey=0, table contents don't-care. FSM=IDLE.
- FSM states: IDLE, LOADPC1, EXPAND, READY.
- IDLE: first clock after reset release -> LOADPC1 if AUTO_EXPAND=1, otherwise waits for key_load.
- key_load=1 in any state: key_reg<=key_in, ready<=0, next state LOADPC1. This aborts an in-flight expansion, and the table is rewritten from round 0. Takes priority over every other transition.
- LOADPC1 (1 cycle): {C,D}<=PC1(key_reg), cnt<=0, busy=1 -> EXPAND.
- EXPAND (16 cycles, cnt 0..15): shift s=1 for cnt in {0,1,8,15}, else s=2. C,D rotate left by s independently (28-bit wrap). table[cnt]<=PC2(rotated C,D). cnt+1. After cnt=15 -> READY.
- READY: busy=0, ready=1. Holds until the next key_load.
- Latency: key_load sampled at edge 0 -> LOADPC1 at edge 1 -> writes at edges 2..17 -> ready=1 after edge 17, i.e. 17 cycles of busy and ready visible in cycle 18.
- busy=1 exactly in LOADPC1 and EXPAND. ready and busy are never both 1.
- Read port: on the edge where rd_en=1 and ready=1, roundkey<=table[rd_decrypt ? 15-rd_round : rd_round] and rd_valid<=1. Otherwise rd_valid<=0 and roundkey holds its value.
- A read accepted in the same cycle as key_load is serviced from the old table with rd_valid=1. ready drops the next cycle.
- The 4-bit index arithmetic is unsigned, so 15-rd_round never wraps.
- No combinational path exists from the inputs to the outputs.

Test Plan:
- Key 64'h133457799BBCDFF1 loaded, wait for ready, read round 0 encrypt -> roundkey=48'h1B02EFFC7072. Read round 15 -> 48'hCB3D8B0E17F5.
- Same key, rd_decrypt=1, rd_round=0 -> 48'hCB3D8B0E17F5. rd_round=15 -> 48'h1B02EFFC7072.
- Reset with AUTO_EXPAND=1, no load: ready rises in cycle 18 after release. All 16 rounds match the golden software schedule of 64'hFEF9545BB7A45DFD.
- key_load with a second key at EXPAND cnt=7: busy stays high and ready stays 0 for 17 cycles from the new load. The table then fully matches the second key, with no stale rounds.
- rd_en during busy -> rd_valid=0 and roundkey unchanged. Also check key_load coincident with rd_en in READY: the old key's round key is returned with rd_valid=1, and ready=0 on the next cycle.
- Assert rst_n mid-EXPAND -> outputs zero immediately (asynchronous). After release, the table is re-expanded from DEFAULT_KEY, not the previously loaded key.

Source files
------------

// File: rtl/des_keysched_seq.sv
// -----------------------------------------------------------------------------
// des_keysched_seq
// Runtime-keyed DES round-key generator. A 64-bit key is captured, reduced by
// PC-1 into C/D halves, and the 16 round keys are produced one per cycle
// (rotate C/D, apply PC-2) into a 16x48 table. A registered read port returns
// any round key in encrypt order or reversed (decrypt) order.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   key_load    in   1   strobe: capture key_in, (re)start expansion
//   key_in      in  64   DES key, MSB = DES bit 1 (parity bits ignored)
//   busy        out  1   expansion in progress
//   ready       out  1   table holds the complete schedule of the current key
//   rd_en       in   1   read request
//   rd_round    in   4   logical round index 0..15
//   rd_decrypt  in   1   1: physical index = 15 - rd_round
//   roundkey    out 48   round key, MSB = PC-2 bit 1
//   rd_valid    out  1   roundkey valid for the previous cycle's request
// -----------------------------------------------------------------------------
module des_keysched_seq #(
   parameter logic [63:0] DEFAULT_KEY = 64'hFEF9545BB7A45DFD,
   parameter bit          AUTO_EXPAND = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        key_load,
   input  logic [63:0] key_in,
   output logic        busy,
   output logic        ready,
   input  logic        rd_en,
   input  logic [3:0]  rd_round,
   input  logic        rd_decrypt,
   output logic [47:0] roundkey,
   output logic        rd_valid
);

   localparam int unsigned KEY_W    = 64;
   localparam int unsigned CD_W     = 28;
   localparam int unsigned PC1_W    = 56;
   localparam int unsigned RK_W     = 48;
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned N_ROUNDS = 16;

   // Entries are DES bit numbers (1 = MSB of the source vector).
   localparam int unsigned PC1_TAB [PC1_W] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2_TAB [RK_W] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOADPC1 = 2'd1,
      S_EXPAND  = 2'd2,
      S_READY   = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_load_cd;
   logic                w_step;

   logic [KEY_W-1:0]    r_key;
   logic [CD_W-1:0]     r_c;
   logic [CD_W-1:0]     r_d;
   logic [IDX_W-1:0]    r_cnt;
   logic                r_busy;
   logic                r_ready;
   logic [RK_W-1:0]     r_table [N_ROUNDS];
   logic [RK_W-1:0]     r_roundkey;
   logic                r_rd_valid;

   logic [PC1_W-1:0]    w_pc1;
   logic                w_shift2;
   logic [CD_W-1:0]     w_c_rot;
   logic [CD_W-1:0]     w_d_rot;
   logic [PC1_W-1:0]    w_cd_rot;
   logic [RK_W-1:0]     w_pc2;
   logic [IDX_W-1:0]    w_rd_idx;
   logic                w_unused_parity;

   // PC-1: 64-bit key -> {C,D}; parity bits 8,16,...,64 are never selected.
   for (genvar g = 0; g < PC1_W; g++) begin : g_pc1
      assign w_pc1[PC1_W-1-g] = r_key[KEY_W-PC1_TAB[g]];
   end

   // Parity bits travel in the key register but are dropped by PC-1.
   assign w_unused_parity = ^{r_key[0],  r_key[8],  r_key[16], r_key[24],
                              r_key[32], r_key[40], r_key[48], r_key[56]};

   // Rounds 1, 2, 9 and 16 rotate by one, all others by two.
   assign w_shift2 = !((r_cnt == 4'd0) || (r_cnt == 4'd1) ||
                       (r_cnt == 4'd8) || (r_cnt == 4'd15));

   assign w_c_rot  = w_shift2 ? {r_c[CD_W-3:0], r_c[CD_W-1:CD_W-2]}
                              : {r_c[CD_W-2:0], r_c[CD_W-1]};
   assign w_d_rot  = w_shift2 ? {r_d[CD_W-3:0], r_d[CD_W-1:CD_W-2]}
                              : {r_d[CD_W-2:0], r_d[CD_W-1]};
   assign w_cd_rot = {w_c_rot, w_d_rot};

   // PC-2 on the rotated halves, so the round key is written in the same cycle.
   for (genvar g = 0; g < RK_W; g++) begin : g_pc2
      assign w_pc2[RK_W-1-g] = w_cd_rot[PC1_W-PC2_TAB[g]];
   end

   assign w_rd_idx = rd_decrypt ? (4'd15 - rd_round) : rd_round;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and datapath controls; key_load overrides every transition.
   always_comb begin
      w_state_nxt = r_state;
      w_load_cd   = 1'b0;
      w_step      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (AUTO_EXPAND) begin
               w_state_nxt = S_LOADPC1;
            end
         end
         S_LOADPC1: begin
            w_load_cd   = 1'b1;
            w_state_nxt = S_EXPAND;
         end
         S_EXPAND: begin
            w_step = 1'b1;
            if (r_cnt == 4'd15) begin
               w_state_nxt = S_READY;
            end
         end
         S_READY: begin
            w_state_nxt = S_READY;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (key_load) begin
         w_state_nxt = S_LOADPC1;
         w_load_cd   = 1'b0;
         w_step      = 1'b0;
      end
   end

   // Key register, C/D halves, round counter and status flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key   <= DEFAULT_KEY;
         r_c     <= '0;
         r_d     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_ready <= 1'b0;
      end else begin
         if (key_load) begin
            r_key <= key_in;
         end
         if (w_load_cd) begin
            r_c   <= w_pc1[PC1_W-1:CD_W];
            r_d   <= w_pc1[CD_W-1:0];
            r_cnt <= '0;
         end else if (w_step) begin
            r_c   <= w_c_rot;
            r_d   <= w_d_rot;
            r_cnt <= r_cnt + 4'd1;
         end
         // Flags follow the state being entered so they line up with it.
         r_busy  <= (w_state_nxt == S_LOADPC1) || (w_state_nxt == S_EXPAND);
         r_ready <= (w_state_nxt == S_READY);
      end
   end

   // Round-key table; contents are meaningless until ready.
   always_ff @(posedge clk) begin
      if (w_step) begin
         r_table[r_cnt] <= w_pc2;
      end
   end

   // Read port: serviced only while the table is complete; roundkey holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_roundkey <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         if (rd_en && r_ready) begin
            r_roundkey <= r_table[w_rd_idx];
            r_rd_valid <= 1'b1;
         end else begin
            r_rd_valid <= 1'b0;
         end
      end
   end

   assign busy     = r_busy;
   assign ready    = r_ready;
   assign roundkey = r_roundkey;
   assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_des_keysched_seq.sv
// -----------------------------------------------------------------------------
// tb_des_keysched_seq
// Self-checking bench for des_keysched_seq. Expected round keys come from an
// independent software DES key schedule and published reference values; read
// requests push their expected key into a scoreboard popped on rd_valid.
// -----------------------------------------------------------------------------
module tb_des_keysched_seq;

   localparam logic [63:0] DEF_KEY = 64'hFEF9545BB7A45DFD;
   localparam logic [63:0] K1      = 64'h133457799BBCDFF1;
   localparam logic [63:0] K2      = 64'h0E329232EA6D0D73;
   localparam logic [63:0] K3      = 64'h3B3898371520F75E;

   logic        clk;
   logic        rst_n;
   logic        key_load;
   logic [63:0] key_in;
   logic        busy;
   logic        ready;
   logic        rd_en;
   logic [3:0]  rd_round;
   logic        rd_decrypt;
   logic [47:0] roundkey;
   logic        rd_valid;

   int          n_checks;
   int          n_fail;
   logic [47:0] sb_q [$];
   logic [47:0] exp_tab [16];

   int pc1_t [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   int pc2_t [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   int shift_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   des_keysched_seq #(
      .DEFAULT_KEY (DEF_KEY),
      .AUTO_EXPAND (1'b1)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_load   (key_load),
      .key_in     (key_in),
      .busy       (busy),
      .ready      (ready),
      .rd_en      (rd_en),
      .rd_round   (rd_round),
      .rd_decrypt (rd_decrypt),
      .roundkey   (roundkey),
      .rd_valid   (rd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Software key schedule in DES 1-based bit numbering.
   function automatic void build_sched(input logic [63:0] key);
      logic [1:64] k;
      logic [1:28] c;
      logic [1:28] d;
      logic [1:56] cd;
      logic [1:48] sub;
      k = key;
      for (int i = 1; i <= 28; i++) begin
         c[i] = k[pc1_t[i-1]];
         d[i] = k[pc1_t[i+27]];
      end
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < shift_t[r]; s++) begin
            c = {c[2:28], c[1]};
            d = {d[2:28], d[1]};
         end
         cd = {c, d};
         for (int j = 1; j <= 48; j++) begin
            sub[j] = cd[pc2_t[j-1]];
         end
         exp_tab[r] = sub;
      end
   endfunction

   // Advance one clock and check the read port against the scoreboard.
   task automatic tick();
      logic [47:0] e;
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("rd_valid", 64'(rd_valid), 64'd1);
         if (rd_valid) chk("roundkey", 64'(roundkey), 64'(e));
      end else begin
         chk("rd_valid_idle", 64'(rd_valid), 64'd0);
      end
   endtask

   task automatic rd(input int r, input bit dec, input logic [47:0] e);
      rd_en      = 1'b1;
      rd_round   = 4'(r);
      rd_decrypt = dec;
      sb_q.push_back(e);
      tick();
      rd_en      = 1'b0;
   endtask

   task automatic rd_all(input bit dec);
      for (int r = 0; r < 16; r++) begin
         rd(r, dec, exp_tab[dec ? 15 - r : r]);
      end
   endtask

   task automatic load_key(input logic [63:0] k);
      key_in   = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!ready && n < 64) begin
         tick();
         n++;
         chk("busy_and_ready", 64'(busy & ready), 64'd0);
         if (!ready) chk("busy_while_expanding", 64'(busy), 64'd1);
      end
      if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
   endtask

   initial begin
      int          n;
      logic [47:0] prev;
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      key_load   = 1'b0;
      key_in     = '0;
      rd_en      = 1'b0;
      rd_round   = '0;
      rd_decrypt = 1'b0;

      #12;
      chk("rst_busy",     64'(busy),     64'd0);
      chk("rst_ready",    64'(ready),    64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_roundkey", 64'(roundkey), 64'd0);

      // Automatic expansion of the default key after reset release.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_ready(n);
      chk("auto_ready_cycle", 64'(n), 64'd18);
      build_sched(DEF_KEY);
      rd_all(1'b0);

      // Reference key with published round keys.
      load_key(K1);
      chk("load_busy",  64'(busy),  64'd1);
      chk("load_ready", 64'(ready), 64'd0);
      wait_ready(n);
      chk("load_latency", 64'(n), 64'd17);
      rd(0,  1'b0, 48'h1B02EFFC7072);
      rd(15, 1'b0, 48'hCB3D8B0E17F5);
      rd(0,  1'b1, 48'hCB3D8B0E17F5);
      rd(15, 1'b1, 48'h1B02EFFC7072);
      build_sched(K1);
      rd_all(1'b1);

      // Abort an expansion at cnt=7 with a new key; also read while busy.
      load_key(K2);
      repeat (7) tick();
      prev       = roundkey;
      rd_en      = 1'b1;
      rd_round   = 4'd3;
      rd_decrypt = 1'b0;
      tick();
      rd_en      = 1'b0;
      chk("busy_read_hold", 64'(roundkey), 64'(prev));
      load_key(K3);
      chk("abort_busy",  64'(busy),  64'd1);
      chk("abort_ready", 64'(ready), 64'd0);
      wait_ready(n);
      chk("abort_latency", 64'(n), 64'd17);
      build_sched(K3);
      rd_all(1'b0);
      rd_all(1'b1);

      // key_load coincident with a read: old table answers, ready drops.
      rd_en      = 1'b1;
      rd_round   = 4'd5;
      rd_decrypt = 1'b0;
      key_in     = K1;
      key_load   = 1'b1;
      sb_q.push_back(exp_tab[5]);
      tick();
      rd_en      = 1'b0;
      key_load   = 1'b0;
      chk("coincident_ready", 64'(ready), 64'd0);
      chk("coincident_busy",  64'(busy),  64'd1);

      // Asynchronous reset in the middle of expansion.
      repeat (5) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_busy",     64'(busy),     64'd0);
      chk("async_ready",    64'(ready),    64'd0);
      chk("async_rd_valid", 64'(rd_valid), 64'd0);
      chk("async_roundkey", 64'(roundkey), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_ready(n);
      chk("rerst_ready_cycle", 64'(n), 64'd18);
      build_sched(DEF_KEY);
      rd_all(1'b1);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
